uart_tx_ticked: RTL and testbench



---
 rtl/uart_tx_ticked_pkg.sv | 17 +
 rtl/rise_tick.sv | 21 ++
 rtl/uart_tx_ticked.sv | 146 ++++++++++++++
 tb/tb_uart_tx_ticked.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ticked_pkg.sv
// rtl/uart_tx_ticked_pkg.sv - shared FSM encoding and parity mode constants for the ticked UART transmitter
package uart_tx_ticked_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/rise_tick.sv
// rtl/rise_tick.sv - turns a slow level (divider output) into a one-cycle rising-edge tick
module rise_tick (
    input  logic clock_in,
    input  logic reset,
    input  logic level,
    output logic tick
);

    logic level_q;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign tick = level & ~level_q;

endmodule

// File: rtl/uart_tx_ticked.sv
// rtl/uart_tx_ticked.sv - UART transmitter paced by ticks derived from the clock divider output
module uart_tx_ticked #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    import uart_tx_ticked_pkg::*;

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] DATA_BITS_C = CW'(DATA_BITS);
    localparam logic [1:0]    STOP_BITS_C = 2'(STOP_BITS);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY < 0 || PARITY > 2) begin : g_param_check
            $error("uart_tx_ticked: illegal DATA_BITS/PARITY/STOP_BITS");
        end
    endgenerate

    tx_state_t            state;
    tx_state_t            state_next;
    logic                 tick;
    logic                 accept;
    logic [DATA_BITS-1:0] shift;
    logic [CW-1:0]        bit_cnt;
    logic [1:0]           stop_cnt;
    logic                 par_bit;
    logic                 data_last;
    logic                 stop_last;

    rise_tick u_rise_tick (
        .clock_in (clock_in),
        .reset    (reset),
        .level    (baud_clk),
        .tick     (tick)
    );

    assign accept    = in_valid & in_ready;
    assign data_last = (bit_cnt >= DATA_BITS_C);
    assign stop_last = (stop_cnt >= STOP_BITS_C);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick seen in IDLE is ignored, so accept always waits in ALIGN for a fresh bit boundary
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_ALIGN;
            ST_ALIGN:  if (tick) state_next = ST_START;
            ST_START:  if (tick) state_next = ST_DATA;
            ST_DATA:   if (tick && data_last) state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_next = ST_STOP;
            ST_STOP:   if (tick && stop_last) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE) & ~reset;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            par_bit  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift   <= in_data;
                        par_bit <= (PARITY == PAR_ODD) ? ~^in_data : ^in_data;
                        busy    <= 1'b1;
                    end
                end
                ST_ALIGN: begin
                    if (tick) tx <= 1'b0;
                end
                ST_START: begin
                    if (tick) begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= CW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (!data_last) begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + CW'(1);
                        end else if (PARITY != PAR_NONE) begin
                            tx <= par_bit;
                        end else begin
                            tx       <= 1'b1;
                            stop_cnt <= 2'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 2'd1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!stop_last) begin
                            stop_cnt <= stop_cnt + 2'd1;
                        end else begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ticked.sv
// tb/tb_uart_tx_ticked.sv - self-checking bench for uart_tx_ticked against a frame-level model
module tb_uart_tx_ticked;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       div_run;
    logic [1:0] div_cnt = 2'd0;
    logic       baud_clk;
    logic [7:0] in_data;
    logic       v0, v1;
    logic       r0, r1, tx0, tx1, b0, b1, d0, d1;
    logic       sel;
    int         checks = 0;
    int         errors = 0;

    always #5 clock_in = ~clock_in;

    // Divide-by-4 reference: one rising edge of baud_clk every 4 system clocks
    always @(posedge clock_in) if (div_run) div_cnt <= div_cnt + 2'd1;
    assign baud_clk = div_run & div_cnt[1];

    uart_tx_ticked #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clock_in (clock_in), .reset (reset), .baud_clk (baud_clk),
        .in_data (in_data), .in_valid (v0), .in_ready (r0),
        .tx (tx0), .busy (b0), .done (d0)
    );

    uart_tx_ticked #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clock_in (clock_in), .reset (reset), .baud_clk (baud_clk),
        .in_data (in_data), .in_valid (v1), .in_ready (r1),
        .tx (tx1), .busy (b1), .done (d1)
    );

    wire tx_s    = sel ? tx1 : tx0;
    wire busy_s  = sel ? b1 : b0;
    wire done_s  = sel ? d1 : d0;
    wire ready_s = sel ? r1 : r0;

    task automatic set_valid(input logic val);
        if (sel) v1 = val;
        else     v0 = val;
    endtask

    // Expected line levels, one entry per bit period: start, data LSB first, parity, stop(s)
    function automatic logic [15:0] model_frame(input logic [7:0] data, input int par,
                                                input int nstop, output int n);
        logic [15:0] f;
        int ones;
        f = '0;
        n = 0;
        f[n] = 1'b0; n = n + 1;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[n] = data[i]; n = n + 1;
            if (data[i]) ones = ones + 1;
        end
        if (par == 2) begin f[n] = (ones % 2 == 1); n = n + 1; end
        if (par == 1) begin f[n] = (ones % 2 == 0); n = n + 1; end
        for (int s = 0; s < nstop; s++) begin f[n] = 1'b1; n = n + 1; end
        return f;
    endfunction

    function automatic void decode(input logic [127:0] tr, input int t0, input int n,
                                   output logic [15:0] obs, output bit stable);
        obs = '0;
        stable = (t0 >= 0);
        if (t0 < 0) return;
        for (int i = 0; i < n; i++) begin
            obs[i] = tr[t0 + 4*i];
            for (int c = 1; c < 4; c++)
                if (tr[t0 + 4*i + c] !== tr[t0 + 4*i]) stable = 0;
        end
    endfunction

    // Hands one byte over and records tx each cycle from the accept until done
    task automatic send_and_capture(input logic [7:0] data, input logic [7:0] post_data,
                                    input bit keep, input int stall,
                                    output int t_start, output int t_done, output logic [127:0] tr,
                                    output bit busy_drop, output bit stall_bad, output bit timeout);
        timeout = 0; stall_bad = 0; busy_drop = 0; t_start = -1; t_done = -1; tr = '1;
        for (int k = 0; k < 200 && ready_s !== 1'b1; k++) @(negedge clock_in);
        if (ready_s !== 1'b1) begin timeout = 1; return; end
        in_data = data;
        set_valid(1'b1);
        @(posedge clock_in);
        @(negedge clock_in);
        in_data = post_data;
        if (!keep) set_valid(1'b0);
        if (stall > 0) begin
            div_run = 1'b0;
            for (int k = 0; k < stall; k++) begin
                if (tx_s !== 1'b1 || busy_s !== 1'b1 || ready_s !== 1'b0 || done_s !== 1'b0)
                    stall_bad = 1;
                @(negedge clock_in);
            end
            div_run = 1'b1;
        end
        for (int j = 0; j < 128; j++) begin
            tr[j] = tx_s;
            if (t_start < 0 && tx_s === 1'b0) t_start = j;
            if (done_s === 1'b1) begin t_done = j; break; end
            if (busy_s !== 1'b1) busy_drop = 1;
            @(negedge clock_in);
        end
        if (t_done < 0) timeout = 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock_in);
        checks++; if (tx0 !== 1'b1 || tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b%b want 11", tx0, tx1); end
        checks++; if (b0 !== 1'b0 || b1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", b0, b1); end
        checks++; if (d0 !== 1'b0 || d1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b%b want 00", d0, d1); end
        checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", r0, r1); end
        reset = 1'b0;
        #1;
        checks++; if (r0 !== 1'b1 || r1 !== 1'b1) begin errors++; $display("FAIL release_ready: got %b%b want 11", r0, r1); end
    endtask

    task automatic test_basic;
        int ts, td, n; logic [127:0] tr; bit bd, sb, to, st; logic [15:0] exp, obs;
        sel = 1'b0;
        send_and_capture(8'h55, 8'h55, 0, 0, ts, td, tr, bd, sb, to);
        exp = model_frame(8'h55, 0, 1, n);
        decode(tr, ts, n, obs, st);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got timeout want done"); end
        checks++; if (ts < 1 || ts > 4) begin errors++; $display("FAIL basic_align: got %0d want 1..4", ts); end
        checks++; if (obs !== exp || !st) begin errors++; $display("FAIL basic_bits: got %h stable %0d want %h", obs, st, exp); end
        checks++; if (td !== ts + 4*n) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", td, ts + 4*n); end
        checks++; if (td > 44) begin errors++; $display("FAIL basic_latency: got %0d want <=44", td); end
        checks++; if (bd) begin errors++; $display("FAIL basic_busy: got drop want held"); end
        @(negedge clock_in);
        checks++; if (done_s !== 1'b0 || busy_s !== 1'b0 || tx_s !== 1'b1) begin
            errors++; $display("FAIL basic_after: got done %b busy %b tx %b want 0 0 1", done_s, busy_s, tx_s); end
    endtask

    task automatic test_parity_two_stop;
        int ts, td, n; logic [127:0] tr; bit bd, sb, to, st; logic [15:0] exp, obs;
        sel = 1'b1;
        send_and_capture(8'hA3, 8'hA3, 0, 0, ts, td, tr, bd, sb, to);
        exp = model_frame(8'hA3, 2, 2, n);
        decode(tr, ts, n, obs, st);
        checks++; if (to) begin errors++; $display("FAIL par_timeout: got timeout want done"); end
        checks++; if (obs !== exp || !st) begin errors++; $display("FAIL par_bits: got %h stable %0d want %h", obs, st, exp); end
        checks++; if (td !== ts + 4*n) begin errors++; $display("FAIL par_done_time: got %0d want %0d", td, ts + 4*n); end
        checks++; if (bd) begin errors++; $display("FAIL par_busy: got drop want held"); end
    endtask

    task automatic test_back_to_back;
        int ts, td, n; logic [127:0] tr; bit bd, sb, to, st; logic [15:0] exp, obs;
        sel = 1'b0;
        send_and_capture(8'h01, 8'h02, 1, 0, ts, td, tr, bd, sb, to);
        exp = model_frame(8'h01, 0, 1, n);
        decode(tr, ts, n, obs, st);
        checks++; if (to || obs !== exp || !st || td !== ts + 4*n) begin
            errors++; $display("FAIL b2b_first: got %h td %0d want %h td %0d", obs, td, exp, ts + 4*n); end
        send_and_capture(8'h02, 8'h5A, 0, 0, ts, td, tr, bd, sb, to);
        exp = model_frame(8'h02, 0, 1, n);
        decode(tr, ts, n, obs, st);
        checks++; if (to || obs !== exp || !st || td !== ts + 4*n) begin
            errors++; $display("FAIL b2b_second: got %h td %0d want %h td %0d", obs, td, exp, ts + 4*n); end
        checks++; if (ts < 1 || ts > 4) begin errors++; $display("FAIL b2b_gap: got %0d want 1..4", ts); end
        begin
            bit again = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clock_in);
                if (busy_s !== 1'b0 || tx_s !== 1'b1) again = 1;
            end
            checks++; if (again) begin errors++; $display("FAIL b2b_once: got extra frame want none"); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int ts, td, n; logic [127:0] tr; bit bd, sb, to, st, saw_done, saw_start; logic [15:0] exp, obs;
        sel = 1'b0;
        for (int k = 0; k < 200 && ready_s !== 1'b1; k++) @(negedge clock_in);
        in_data = 8'($urandom);
        set_valid(1'b1);
        @(posedge clock_in); @(negedge clock_in);
        set_valid(1'b0);
        saw_start = 0;
        for (int k = 0; k < 10 && !saw_start; k++) begin
            if (tx_s === 1'b0) saw_start = 1;
            else @(negedge clock_in);
        end
        checks++; if (!saw_start) begin errors++; $display("FAIL rst_start: got no start want start"); end
        repeat (17) @(negedge clock_in);
        reset = 1'b1;
        @(posedge clock_in); @(negedge clock_in);
        reset = 1'b0;
        #1;
        checks++; if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0 || ready_s !== 1'b1) begin
            errors++; $display("FAIL rst_mid: got tx %b busy %b done %b ready %b want 1 0 0 1", tx_s, busy_s, done_s, ready_s); end
        saw_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock_in);
            if (done_s === 1'b1 || tx_s !== 1'b1) saw_done = 1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL rst_no_done: got activity want idle"); end
        send_and_capture(8'hFF, 8'hFF, 0, 0, ts, td, tr, bd, sb, to);
        exp = model_frame(8'hFF, 0, 1, n);
        decode(tr, ts, n, obs, st);
        checks++; if (to || obs !== exp || !st || td !== ts + 4*n) begin
            errors++; $display("FAIL rst_recover: got %h td %0d want %h td %0d", obs, td, exp, ts + 4*n); end
    endtask

    task automatic test_stall;
        int ts, td, n; logic [127:0] tr; bit bd, sb, to, st; logic [15:0] exp, obs; logic [7:0] d;
        sel = 1'b1;
        d = 8'($urandom);
        send_and_capture(d, d, 0, 100, ts, td, tr, bd, sb, to);
        exp = model_frame(d, 2, 2, n);
        decode(tr, ts, n, obs, st);
        checks++; if (sb) begin errors++; $display("FAIL stall_hold: got line activity want tx=1 busy=1"); end
        checks++; if (to || obs !== exp || !st || td !== ts + 4*n) begin
            errors++; $display("FAIL stall_resume: got %h td %0d want %h td %0d", obs, td, exp, ts + 4*n); end
    endtask

    task automatic test_data_change;
        int ts, td, n; logic [127:0] tr; bit bd, sb, to, st; logic [15:0] exp, obs;
        sel = 1'b0;
        send_and_capture(8'hF0, 8'h00, 0, 0, ts, td, tr, bd, sb, to);
        exp = model_frame(8'hF0, 0, 1, n);
        decode(tr, ts, n, obs, st);
        checks++; if (to || obs !== exp || !st) begin
            errors++; $display("FAIL data_change: got %h want %h", obs, exp); end
    endtask

    task automatic test_random;
        int ts, td, n; logic [127:0] tr; bit bd, sb, to, st; logic [15:0] exp, obs; logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clock_in);
            d = 8'($urandom);
            send_and_capture(d, 8'($urandom), 0, 0, ts, td, tr, bd, sb, to);
            exp = model_frame(d, sel ? 2 : 0, sel ? 2 : 1, n);
            decode(tr, ts, n, obs, st);
            checks++; if (to || obs !== exp || !st || td !== ts + 4*n || bd || ts < 1 || ts > 4) begin
                errors++; $display("FAIL random_%0d: dut %0d data %h got %h ts %0d td %0d want %h td %0d",
                                   i, sel, d, obs, ts, td, exp, ts + 4*n); end
        end
    endtask

    initial begin
        reset = 1'b1; div_run = 1'b1; v0 = 1'b0; v1 = 1'b0; in_data = 8'h00; sel = 1'b0;
        @(negedge clock_in);
        test_reset;
        test_basic;
        test_parity_two_stop;
        test_back_to_back;
        test_reset_mid_frame;
        test_stall;
        test_data_change;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
